vga_scan_doubler: RTL and testbench

- Parametrised successor to the fixed VGA/HDMI sync stage. Captures native-rate indexed pixels (pixel_color3 stage) into a ping-pong line buffer and replays each line twice at double pixel rate.
- Generates programmable hsync/vsync/active windows, with wrap-around support, for the external HDMI encoder or VGA DAC.
- Sits between the vicii core and the color translation block; runs entirely on clk_dot4x.

---
 rtl/vga_scan_doubler.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_vga_scan_doubler.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_doubler.sv
// ============================================================================
// vga_scan_doubler
// ----------------------------------------------------------------------------
// Line-doubling scan converter. Native-rate indexed pixels are written into
// one bank of a ping-pong line buffer (bank = raster_line[0]). The other
// bank, holding the previous native line, is replayed twice at double pixel
// rate. Programmable hsync/vsync/active windows with wrap-around support are
// generated on the output coordinates. Everything runs on clk_dot4x.
//
// Optional feature (compile-time macro VGA_SCANLINES_EN):
//   defined   : half_bright = scanline_en & out_y[0] & active, registered and
//               aligned with pixel_out.
//   undefined : half_bright is tied 0 and scanline_en is ignored.
//
// Ports:
//   clk_dot4x    4x dot clock, the only clock
//   rst          synchronous active-high reset
//   dot_en       one-cycle strobe per native pixel (every 4th clk_dot4x)
//   raster_x     native x of pixel_in
//   raster_line  native line of pixel_in
//   pixel_in     native indexed colour
//   line_len     native pixels per line (clipped to LINE_DEPTH)
//   hs_sta/hs_end, ha_sta/ha_end   horizontal sync / active window (out_x)
//   vs_sta/vs_end, va_sta/va_end   vertical sync / active window (out_y)
//   scanline_en  scanline dimming request (optional feature only)
//   pixel_out    doubled-rate indexed colour, 0 when not active
//   out_x/out_y  output coordinates, aligned with pixel_out
//   hsync/vsync  sync outputs, polarity set by HS_POL / VS_POL
//   active       visible-area flag
//   half_bright  scanline dim flag
// ============================================================================
module vga_scan_doubler #(
    parameter int COLOR_W    = 4,
    parameter int XBITS      = 10,
    parameter int YBITS      = 9,
    parameter int LINE_DEPTH = 520,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0
) (
    input  logic               clk_dot4x,
    input  logic               rst,
    input  logic               dot_en,
    input  logic [XBITS-1:0]   raster_x,
    input  logic [YBITS-1:0]   raster_line,
    input  logic [COLOR_W-1:0] pixel_in,
    input  logic [XBITS-1:0]   line_len,
    input  logic [XBITS-1:0]   hs_sta,
    input  logic [XBITS-1:0]   hs_end,
    input  logic [XBITS-1:0]   ha_sta,
    input  logic [XBITS-1:0]   ha_end,
    input  logic [YBITS:0]     vs_sta,
    input  logic [YBITS:0]     vs_end,
    input  logic [YBITS:0]     va_sta,
    input  logic [YBITS:0]     va_end,
    input  logic               scanline_en,
    output logic [COLOR_W-1:0] pixel_out,
    output logic [XBITS-1:0]   out_x,
    output logic [YBITS:0]     out_y,
    output logic               hsync,
    output logic               vsync,
    output logic               active,
    output logic               half_bright
);

    localparam int AW = (LINE_DEPTH > 1) ? $clog2(LINE_DEPTH) : 1;
    localparam int WW = (XBITS > YBITS + 1) ? XBITS : YBITS + 1;
    localparam logic [XBITS:0] DEPTH_X = (XBITS + 1)'(LINE_DEPTH);

    // Window indices into the evaluator arrays
    localparam int W_HS = 0;
    localparam int W_HA = 1;
    localparam int W_VS = 2;
    localparam int W_VA = 3;

    // ------------------------------------------------------------------
    // Double-rate enable: the dot_en cycle and the cycle two later.
    // ------------------------------------------------------------------
    logic dot_d1_reg;
    logic dot_d2_reg;
    logic dbl_en;
    logic resync;

    assign dbl_en = dot_en | dot_d2_reg;
    assign resync = dot_en && (raster_x == '0);

    // ------------------------------------------------------------------
    // Read-side counters
    // ------------------------------------------------------------------
    logic [XBITS-1:0] x_cnt_reg;
    logic [XBITS-1:0] x_cnt_next;
    logic [YBITS:0]   y_cnt_reg;
    logic [YBITS:0]   y_cnt_next;
    logic [YBITS:0]   y_lim_reg;
    logic             synced_reg;

    logic [XBITS-1:0] addr_x;
    logic [YBITS:0]   addr_y;
    logic [YBITS:0]   y_lim;
    logic             sync_now;
    logic [XBITS:0]   eff_len;
    logic             x_wrap;

    always_comb begin
        // A resync cycle addresses the first pixel of the new line directly,
        // so the counters already hold the second address afterwards.
        addr_x   = resync ? '0 : x_cnt_reg;
        addr_y   = resync ? {raster_line, 1'b0} : y_cnt_reg;
        y_lim    = resync ? {raster_line, 1'b1} : y_lim_reg;
        sync_now = synced_reg | resync;

        eff_len  = ({1'b0, line_len} > DEPTH_X) ? DEPTH_X : {1'b0, line_len};

        // ">=" rather than "==" keeps the counter in range even if line_len
        // shrinks below the current position, and handles line_len == 0.
        x_wrap   = (({1'b0, addr_x} + (XBITS + 1)'(1)) >= eff_len);

        x_cnt_next = x_wrap ? '0 : addr_x + XBITS'(1);
        y_cnt_next = addr_y;
        if (x_wrap) begin
            // Once locked, hold on the second doubled half-line until the
            // next resync; before lock the counter free-runs.
            if (!(sync_now && (addr_y >= y_lim))) begin
                y_cnt_next = addr_y + (YBITS + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            dot_d1_reg <= 1'b0;
            dot_d2_reg <= 1'b0;
            x_cnt_reg  <= '0;
            y_cnt_reg  <= '0;
            y_lim_reg  <= '0;
            synced_reg <= 1'b0;
        end else begin
            dot_d1_reg <= dot_en;
            dot_d2_reg <= dot_d1_reg;
            if (dbl_en) begin
                x_cnt_reg <= x_cnt_next;
                y_cnt_reg <= y_cnt_next;
            end
            if (resync) begin
                y_lim_reg  <= {raster_line, 1'b1};
                synced_reg <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Ping-pong line buffer: one inferred RAM per bank, registered read.
    // The write bank is raster_line[0]; the read bank is its complement.
    // ------------------------------------------------------------------
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;

    assign wr_en   = dot_en && ({1'b0, raster_x} < DEPTH_X);
    assign wr_addr = AW'(raster_x);
    assign rd_addr = AW'(addr_x);

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        logic [COLOR_W-1:0] mem [LINE_DEPTH];
        logic [COLOR_W-1:0] rd_q_reg;

        always_ff @(posedge clk_dot4x) begin
            if (wr_en && (raster_line[0] == 1'(gi))) begin
                mem[wr_addr] <= pixel_in;
            end
            if (dbl_en) begin
                rd_q_reg <= mem[rd_addr];
            end
        end
    end

    // ------------------------------------------------------------------
    // Window evaluators, computed on the address being issued so a window
    // register change is picked up on the next dbl_en.
    // ------------------------------------------------------------------
    logic [WW-1:0] win_c [4];
    logic [WW-1:0] win_s [4];
    logic [WW-1:0] win_e [4];
    logic [3:0]    win_hit;

    always_comb begin
        win_c[W_HS] = WW'(addr_x);
        win_s[W_HS] = WW'(hs_sta);
        win_e[W_HS] = WW'(hs_end);
        win_c[W_HA] = WW'(addr_x);
        win_s[W_HA] = WW'(ha_sta);
        win_e[W_HA] = WW'(ha_end);
        win_c[W_VS] = WW'(addr_y);
        win_s[W_VS] = WW'(vs_sta);
        win_e[W_VS] = WW'(vs_end);
        win_c[W_VA] = WW'(addr_y);
        win_s[W_VA] = WW'(va_sta);
        win_e[W_VA] = WW'(va_end);
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_win
        // start < end : plain window; start > end : window wraps past the
        // end of the axis; start == end : empty.
        assign win_hit[gi] =
            (win_s[gi] < win_e[gi]) ? ((win_c[gi] >= win_s[gi]) && (win_c[gi] < win_e[gi])) :
            (win_s[gi] > win_e[gi]) ? ((win_c[gi] >= win_s[gi]) || (win_c[gi] < win_e[gi])) :
                                      1'b0;
    end

    // ------------------------------------------------------------------
    // Stage 1: metadata travelling alongside the RAM read.
    // ------------------------------------------------------------------
    logic             vld_d1_reg;
    logic [XBITS-1:0] x_d1_reg;
    logic [YBITS:0]   y_d1_reg;
    logic             bank_d1_reg;
    logic             act_d1_reg;
    logic             hs_d1_reg;
    logic             vs_d1_reg;

    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            vld_d1_reg  <= 1'b0;
            x_d1_reg    <= '0;
            y_d1_reg    <= '0;
            bank_d1_reg <= 1'b0;
            act_d1_reg  <= 1'b0;
            hs_d1_reg   <= 1'b0;
            vs_d1_reg   <= 1'b0;
        end else begin
            vld_d1_reg <= dbl_en;
            if (dbl_en) begin
                x_d1_reg    <= addr_x;
                y_d1_reg    <= addr_y;
                bank_d1_reg <= ~raster_line[0];
                // Until the first resync the output stays blanked with
                // syncs inactive.
                act_d1_reg  <= sync_now & win_hit[W_HA] & win_hit[W_VA];
                hs_d1_reg   <= sync_now & win_hit[W_HS];
                vs_d1_reg   <= sync_now & win_hit[W_VS];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: output registers
    // ------------------------------------------------------------------
    logic [COLOR_W-1:0] rd_pix;
    logic [COLOR_W-1:0] pixel_reg;
    logic [XBITS-1:0]   out_x_reg;
    logic [YBITS:0]     out_y_reg;
    logic               hsync_reg;
    logic               vsync_reg;
    logic               active_reg;

    assign rd_pix = bank_d1_reg ? g_bank[1].rd_q_reg : g_bank[0].rd_q_reg;

    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            pixel_reg  <= '0;
            out_x_reg  <= '0;
            out_y_reg  <= '0;
            hsync_reg  <= ~HS_POL;
            vsync_reg  <= ~VS_POL;
            active_reg <= 1'b0;
        end else if (vld_d1_reg) begin
            pixel_reg  <= act_d1_reg ? rd_pix : '0;
            out_x_reg  <= x_d1_reg;
            out_y_reg  <= y_d1_reg;
            hsync_reg  <= hs_d1_reg ? HS_POL : ~HS_POL;
            vsync_reg  <= vs_d1_reg ? VS_POL : ~VS_POL;
            active_reg <= act_d1_reg;
        end
    end

    assign pixel_out = pixel_reg;
    assign out_x     = out_x_reg;
    assign out_y     = out_y_reg;
    assign hsync     = hsync_reg;
    assign vsync     = vsync_reg;
    assign active    = active_reg;

`ifdef VGA_SCANLINES_EN
    logic half_bright_reg;

    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            half_bright_reg <= 1'b0;
        end else if (vld_d1_reg) begin
            half_bright_reg <= scanline_en & y_d1_reg[0] & act_d1_reg;
        end
    end

    assign half_bright = half_bright_reg;
`else
    logic unused_scanline_en;
    assign unused_scanline_en = scanline_en;
    assign half_bright        = 1'b0;
`endif

endmodule

// File: tb/tb_vga_scan_doubler.sv
// ============================================================================
// tb_vga_scan_doubler
// Directed test of vga_scan_doubler with default parameters
// (LINE_DEPTH=520, HS_POL=VS_POL=0). Native lines are driven one dot every
// four clocks; each dot yields two output samples, observed on the falling
// edge once the corresponding dbl_en has propagated through the pipeline.
// Expected coordinates, colours and window states are derived from the
// written pixel patterns and the programmed windows.
// ============================================================================
module tb_vga_scan_doubler;

    logic       clk = 1'b0;
    logic       rst;
    logic       dot_en;
    logic [9:0] raster_x;
    logic [8:0] raster_line;
    logic [3:0] pixel_in;
    logic [9:0] line_len;
    logic [9:0] hs_sta, hs_end, ha_sta, ha_end;
    logic [9:0] vs_sta, vs_end, va_sta, va_end;
    logic       scanline_en;
    logic [3:0] pixel_out;
    logic [9:0] out_x;
    logic [9:0] out_y;
    logic       hsync, vsync, active, half_bright;

    int total = 0;
    int bad   = 0;
    int eff   = 504;
    int prev_x, wraps, hs_low, max_x;

    always #5 clk = ~clk;

    vga_scan_doubler dut (
        .clk_dot4x  (clk),
        .rst        (rst),
        .dot_en     (dot_en),
        .raster_x   (raster_x),
        .raster_line(raster_line),
        .pixel_in   (pixel_in),
        .line_len   (line_len),
        .hs_sta     (hs_sta),
        .hs_end     (hs_end),
        .ha_sta     (ha_sta),
        .ha_end     (ha_end),
        .vs_sta     (vs_sta),
        .vs_end     (vs_end),
        .va_sta     (va_sta),
        .va_end     (va_end),
        .scanline_en(scanline_en),
        .pixel_out  (pixel_out),
        .out_x      (out_x),
        .out_y      (out_y),
        .hsync      (hsync),
        .vsync      (vsync),
        .active     (active),
        .half_bright(half_bright)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int pat(input int p, input int x);
        case (p)
            0:       return x % 16;
            1:       return (x + 3) % 16;
            default: return (x * 7) % 16;
        endcase
    endfunction

    function automatic bit win(input int c, input int s, input int e);
        if (s < e) return (c >= s) && (c < e);
        if (s > e) return (c >= s) || (c < e);
        return 1'b0;
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_out_x"},       int'(out_x),       0);
        chk({tag, "_out_y"},       int'(out_y),       0);
        chk({tag, "_pixel"},       int'(pixel_out),   0);
        chk({tag, "_active"},      int'(active),      0);
        chk({tag, "_hsync"},       int'(hsync),       1);
        chk({tag, "_vsync"},       int'(vsync),       1);
        chk({tag, "_half_bright"}, int'(half_bright), 0);
        $display("step %s: reset values checked, total=%0d", tag, total);
    endtask

    // mode 1: locked output for native line 'line' reading pattern rpat
    // mode 2: not yet locked, output must be blanked with syncs inactive
    task automatic check_sample(input int n, input int line, input int mode, input int rpat);
        int ex, ey, ep, ehs, evs, ehb;
        bit ea;
        if (mode == 1) begin
            ex  = n % eff;
            ey  = 2 * line + ((n >= eff) ? 1 : 0);
            ea  = win(ex, int'(ha_sta), int'(ha_end)) && win(ey, int'(va_sta), int'(va_end));
            ep  = ea ? pat(rpat, ex) : 0;
            ehs = win(ex, int'(hs_sta), int'(hs_end)) ? 0 : 1;
            evs = win(ey, int'(vs_sta), int'(vs_end)) ? 0 : 1;
`ifdef VGA_SCANLINES_EN
            ehb = (scanline_en && (ey % 2 == 1) && ea) ? 1 : 0;
`else
            ehb = 0;
`endif
            chk("out_x",       int'(out_x),       ex);
            chk("out_y",       int'(out_y),       ey);
            chk("active",      int'(active),      int'(ea));
            chk("pixel_out",   int'(pixel_out),   ep);
            chk("hsync",       int'(hsync),       ehs);
            chk("vsync",       int'(vsync),       evs);
            chk("half_bright", int'(half_bright), ehb);
            if (prev_x == eff - 1 && out_x == 10'd0) wraps++;
            if (hsync == 1'b0) hs_low++;
            if (int'(out_x) > max_x) max_x = int'(out_x);
            prev_x = int'(out_x);
        end else if (mode == 2) begin
            chk("unlocked_active",      int'(active),      0);
            chk("unlocked_pixel",       int'(pixel_out),   0);
            chk("unlocked_hsync",       int'(hsync),       1);
            chk("unlocked_vsync",       int'(vsync),       1);
            chk("unlocked_half_bright", int'(half_bright), 0);
        end
    endtask

    // Drives dots x0..x1-1 of one native line, starting on a falling edge.
    task automatic run_line(input int line, input int x0, input int x1,
                            input int wpat, input int mode, input int rpat);
        for (int k = x0; k < x1; k++) begin
            dot_en      = 1'b1;
            raster_x    = 10'(k);
            raster_line = 9'(line);
            pixel_in    = 4'(pat(wpat, k));
            @(negedge clk);
            dot_en = 1'b0;
            @(negedge clk);
            check_sample(2 * k, line, mode, rpat);
            @(negedge clk);
            @(negedge clk);
            check_sample(2 * k + 1, line, mode, rpat);
        end
        $display("step line=%0d dots %0d..%0d mode=%0d: total=%0d bad=%0d",
                 line, x0, x1 - 1, mode, total, bad);
    endtask

    initial begin
        rst         = 1'b1;
        dot_en      = 1'b0;
        raster_x    = '0;
        raster_line = '0;
        pixel_in    = '0;
        scanline_en = 1'b0;
        line_len    = 10'd504;
        hs_sta      = 10'd1000;
        hs_end      = 10'd40;
        ha_sta      = 10'd0;
        ha_end      = 10'd1000;
        vs_sta      = 10'd23;
        vs_end      = 10'd24;
        va_sta      = 10'd0;
        va_end      = 10'd1000;
        prev_x      = -1;
        wraps       = 0;
        hs_low      = 0;
        max_x       = 0;

        // Power-up reset
        repeat (3) @(negedge clk);
        check_reset("init");
        rst = 1'b0;

        // Line 10 fills bank 0 with x mod 16; line 11 replays it twice.
        eff = 504;
        run_line(10, 0, 504, 0, 0, 0);
        prev_x = -1; wraps = 0; hs_low = 0; max_x = 0;
        run_line(11, 0, 504, 0, 1, 0);
        chk("l11_hsync_low_count", hs_low, 80);
        chk("l11_wrap_count",      wraps,  1);
        chk("l11_max_x",           max_x,  503);

        // Line 12 written with (x+3) mod 16, reset asserted mid-line.
        run_line(12, 0, 100, 1, 0, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset("midline");
        rst = 1'b0;
        run_line(12, 100, 504, 1, 2, 0);

        // Next raster_x==0 relocks: line 13 shows line 12's data at y=26.
        prev_x = -1;
        run_line(13, 0, 4, 0, 1, 1);

        // Overflow: line_len 600 clipped to 520, new windows, scanlines on.
        line_len    = 10'd600;
        ha_sta      = 10'd8;
        ha_end      = 10'd500;
        hs_sta      = 10'd100;
        hs_end      = 10'd100;
        vs_sta      = 10'd100;
        vs_end      = 10'd100;
        scanline_en = 1'b1;
        run_line(14, 0, 600, 2, 0, 0);
        eff = 520;
        prev_x = -1; wraps = 0; hs_low = 0; max_x = 0;
        run_line(15, 0, 600, 0, 1, 2);
        chk("l15_wrap_count",      wraps,  2);
        chk("l15_hsync_low_count", hs_low, 0);
        chk("l15_max_x",           max_x,  519);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
